arcade_input_mapper: RTL
========================

# arcade_input_mapper

Parametrised player-input front end for arcade cores. Decodes PS/2 keyboard events, merges them with per-player joystick words, and stretches coin pulses to a fixed length with edge-only retrigger. Adds per-player autofire on button 0 and drives active-low, registered game-side inputs. Sits between `hps_io`/joystick mixing and the game top level, replacing the inline keyboard and button logic in the emu wrapper.

## Interface
Parameters:
- `PLAYERS`, 2: number of players, 1..4.
- `BUTTONS`, 1: fire buttons per player, 1..4.
- `COIN_CYCLES`, 4_915_200: coin output width in clocks (100 ms at 49.152 MHz); ≥2.
- `COIN_SHARED`, 1: 1 = coin bit of any joystick drives coin 0; 0 = joystick p drives coin p.
- `AF_PRESCALE`, 491_520: clocks per autofire tick (10 ms); ≥1.

Ports:
- `clk_49m` in 1: sole clock.
- `reset` in 1: synchronous, active-low.
- `ps2_key` in 11: [10] toggle per event, [9] pressed, [7:0] scancode. [8] (extended) is ignored.
- `joy` in PLAYERS*16: player p at [16p+15:16p], active-high.
  - [0] R, [1] L, [2] D, [3] U.
  - [4+k] button k.
  - [4+BUTTONS] start, [5+BUTTONS] coin, [6+BUTTONS] pause.
- `af_en` in PLAYERS: autofire enable per player.
- `af_rate` in 2: half-period select, 0..3 → 2, 4, 8, 16 ticks.
- `p_dir` out PLAYERS*4: active-low {down,up,right,left} per player.
- `p_btn` out PLAYERS*BUTTONS: active-low.
- `start` out PLAYERS: active-low.
- `coin` out PLAYERS: active-low, stretched.
- `service` out 1: active-low.
- `pause_req` out 1: active-high level.

## Operation
- Keyboard event: a registered copy of `ps2_key[10]` differs from the current value. On an event, the matching key latch takes `ps2_key[9]`. Unmapped codes are ignored.
- Key map:
  - Starts: 1/2/3/4 = 16/1E/26/25.
  - Coins: 5/6/7/8 = 2E/36/3D/3E.
  - Service: 46. Pause: 4D.
  - P1: up 75, down 72, left 6B, right 74; buttons 0..3 = 14, 11, 29, 12.
  - P2: up 1D, down 1B, left 1C, right 23; buttons 0..3 = 2A, 32, 31, 3A.
  - Keys for players ≥ PLAYERS or buttons ≥ BUTTONS are ignored. Players 3/4 have no directional or button keys.
- Merge: raw signal = key latch OR the joystick bit.
- Pause: `pause_req` = pause key OR the pause bit of any joystick.
- Coin stretcher, one per player:
  - Idle state: on a raw rising edge (raw=1, previous=0), load `COIN_CYCLES-1` and assert.
  - Active state: decrement each clock; deassert after the cycle at count 0.
  - Edges during the active window are ignored.
  - A coin held past the window stays deasserted until it is released and pressed again (anti-stuck).
- Autofire, player p, button 0 only, applies when `af_en[p]`=1:
  - Shared prescaler emits a 1-clock tick every `AF_PRESCALE` clocks.
  - On a raw rising edge: phase←1, cnt←0.
  - While held, each tick increments cnt. When cnt reaches half−1: cnt←0 and phase toggles.
  - Output = held AND phase.
  - When `af_en[p]`=0, button 0 passes through unchanged.
- Changing `af_rate` mid-burst takes effect at the next cnt compare. A cnt already ≥ the new half−1 fires on the next tick.

## Timing
- All outputs are registered.
- Joystick bit → output: 1 clock.
- ps2 toggle → output: 2 clocks (event detect, latch, output register).
- Coin: first asserted output 1 clock after the raw edge; asserted for exactly `COIN_CYCLES` clocks.
- Autofire: the first shot appears 1 clock after the press. Shot period = 2·half·`AF_PRESCALE` clocks, aligned to the free-running prescaler.
- Reset (`reset`=0 sampled at a rising edge):
  - All active-low outputs go to 1 and `pause_req` to 0 on the next edge.
  - Key latches, previous-value registers, coin counters, cnt and prescaler are cleared; phase←1.
  - A coin stretch in progress is aborted.
  - A coin still held at release of reset counts as a new edge only if the previous-value register sees 0 first. The register is cleared by reset, so a held coin does register one pulse after reset.
- Simultaneous keyboard key and joystick bit on the same input: OR, with no priority.
- Keyboard release while the joystick still holds the input: output stays asserted.

## Test plan
- Joystick: PLAYERS=2, BUTTONS=1; drive `joy[3]`=1 → `p_dir[2]` (up) = 0 one clock later. Release → 1 one clock later.
- Keyboard: events 0x75 pressed then released, toggling [10] each time → P1 up low 2 clocks after the first event, high 2 clocks after the second. A 0x26 event with PLAYERS=2 → no output change.
- Coin: COIN_CYCLES=8.
  - Hold the coin key for 20 clocks → `coin[0]` low for exactly 8 clocks, then high while still held.
  - Release and press again → a second 8-clock pulse.
  - A re-press inside the window is ignored.
- Shared coin: COIN_SHARED=1, joystick 1 coin bit → `coin[0]` pulses and `coin[1]` stays high.
- Autofire: AF_PRESCALE=4, af_rate=0, `af_en[0]`=1; hold P1 fire 64 clocks → `p_btn[0]` low immediately, then toggles every 2 ticks (8 clocks, tick-aligned). Release → high next clock.
- Reset: assert reset mid-coin-stretch and during a held autofire → all outputs inactive next clock. After release, the prescaler restarts from 0.

Source files
------------

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper
//
// Player-input front end for arcade cores. PS/2 key events are decoded
// into key latches and ORed with per-player joystick words. Coin inputs
// are stretched to a fixed pulse length. Each player gets autofire on
// button 0. Every game-side output is registered and active-low, except
// pause_req_o, which is active-high.
//
// Ports
//   clk_49m_i    sole clock
//   reset_i      synchronous reset, active-low
//   ps2_key_i    [10] toggles once per event, [9] pressed, [7:0] scancode
//   joy_i        16 bits per player, active-high:
//                R, L, D, U, buttons, start, coin, pause
//   af_en_i      autofire enable, one bit per player
//   af_rate_i    autofire half-period select: 2, 4, 8 or 16 ticks
//   p_dir_o      {down, up, right, left} per player, active-low
//   p_btn_o      fire buttons per player, active-low
//   start_o      start per player, active-low
//   coin_o       stretched coin per player, active-low
//   service_o    service key, active-low
//   pause_req_o  pause request level, active-high
//
// Coin stretcher states (one instance per player)
//   state       | meaning
//   COIN_IDLE   | output released; waiting for a raw rising edge
//   COIN_ACTIVE | output asserted; coin_cnt_q counts down to 0

module arcade_input_mapper #(
    parameter int PLAYERS     = 2,
    parameter int BUTTONS     = 1,
    parameter int COIN_CYCLES = 4_915_200,
    parameter int COIN_SHARED = 1,
    parameter int AF_PRESCALE = 491_520
) (
    input  logic                       clk_49m_i,
    input  logic                       reset_i,
    input  logic [10:0]                ps2_key_i,
    input  logic [PLAYERS*16-1:0]      joy_i,
    input  logic [PLAYERS-1:0]         af_en_i,
    input  logic [1:0]                 af_rate_i,
    output logic [PLAYERS*4-1:0]       p_dir_o,
    output logic [PLAYERS*BUTTONS-1:0] p_btn_o,
    output logic [PLAYERS-1:0]         start_o,
    output logic [PLAYERS-1:0]         coin_o,
    output logic                       service_o,
    output logic                       pause_req_o
);

    localparam int CW = $clog2(COIN_CYCLES);
    localparam logic [CW-1:0] COIN_LAST = CW'(COIN_CYCLES - 1);
    localparam int PW = (AF_PRESCALE > 1) ? $clog2(AF_PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(AF_PRESCALE - 1);

    // Key latch layout:
    //   0..3   start 1..4
    //   4..7   coin 1..4
    //   8      service
    //   9      pause
    //   10+4p  {down, up, right, left} for players 0 and 1
    //   18+4p  buttons 0..3 for players 0 and 1
    localparam int NKEY = 26;

    typedef enum logic {
        COIN_IDLE   = 1'b0,
        COIN_ACTIVE = 1'b1
    } coin_state_e;

    // ------------------------------------------------------------------
    // Keyboard event detect and key latches
    // ------------------------------------------------------------------
    logic            ps2_tog_q;
    logic            key_evt;
    logic [NKEY-1:0] key_q, key_d;
    logic            key_hit;
    logic [4:0]      key_idx;
    int              key_ply;
    int              key_btn;

    assign key_evt = ps2_key_i[10] ^ ps2_tog_q;

    always_comb begin
        key_hit = 1'b1;
        key_idx = 5'd0;
        key_ply = 0;
        key_btn = 0;
        case (ps2_key_i[7:0])
            8'h16: begin key_idx = 5'd0;  key_ply = 0; end
            8'h1E: begin key_idx = 5'd1;  key_ply = 1; end
            8'h26: begin key_idx = 5'd2;  key_ply = 2; end
            8'h25: begin key_idx = 5'd3;  key_ply = 3; end
            8'h2E: begin key_idx = 5'd4;  key_ply = 0; end
            8'h36: begin key_idx = 5'd5;  key_ply = 1; end
            8'h3D: begin key_idx = 5'd6;  key_ply = 2; end
            8'h3E: begin key_idx = 5'd7;  key_ply = 3; end
            8'h46: begin key_idx = 5'd8;  end
            8'h4D: begin key_idx = 5'd9;  end
            8'h6B: begin key_idx = 5'd10; key_ply = 0; end
            8'h74: begin key_idx = 5'd11; key_ply = 0; end
            8'h75: begin key_idx = 5'd12; key_ply = 0; end
            8'h72: begin key_idx = 5'd13; key_ply = 0; end
            8'h1C: begin key_idx = 5'd14; key_ply = 1; end
            8'h23: begin key_idx = 5'd15; key_ply = 1; end
            8'h1D: begin key_idx = 5'd16; key_ply = 1; end
            8'h1B: begin key_idx = 5'd17; key_ply = 1; end
            8'h14: begin key_idx = 5'd18; key_ply = 0; key_btn = 0; end
            8'h11: begin key_idx = 5'd19; key_ply = 0; key_btn = 1; end
            8'h29: begin key_idx = 5'd20; key_ply = 0; key_btn = 2; end
            8'h12: begin key_idx = 5'd21; key_ply = 0; key_btn = 3; end
            8'h2A: begin key_idx = 5'd22; key_ply = 1; key_btn = 0; end
            8'h32: begin key_idx = 5'd23; key_ply = 1; key_btn = 1; end
            8'h31: begin key_idx = 5'd24; key_ply = 1; key_btn = 2; end
            8'h3A: begin key_idx = 5'd25; key_ply = 1; key_btn = 3; end
            default: key_hit = 1'b0;
        endcase

        key_d = key_q;
        // Keys belonging to absent players or buttons never set a latch.
        if (key_evt && key_hit && (key_ply < PLAYERS) && (key_btn < BUTTONS)) begin
            key_d[key_idx] = ps2_key_i[9];
        end
    end

    always_ff @(posedge clk_49m_i) begin
        if (!reset_i) begin
            ps2_tog_q <= 1'b0;
            key_q     <= '0;
        end else begin
            ps2_tog_q <= ps2_key_i[10];
            key_q     <= key_d;
        end
    end

    // ------------------------------------------------------------------
    // Autofire prescaler, shared by all players
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q;
    logic          af_tick;
    logic [3:0]    af_half_m1;

    assign af_tick = (presc_q == PRESC_LAST);

    always_ff @(posedge clk_49m_i) begin
        if (!reset_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= af_tick ? '0 : presc_q + 1'b1;
        end
    end

    always_comb begin
        af_half_m1 = 4'd1;
        case (af_rate_i)
            2'd0: af_half_m1 = 4'd1;
            2'd1: af_half_m1 = 4'd3;
            2'd2: af_half_m1 = 4'd7;
            2'd3: af_half_m1 = 4'd15;
            default: af_half_m1 = 4'd1;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-player merge, coin stretcher and autofire
    // ------------------------------------------------------------------
    logic [PLAYERS*4-1:0]       dir_raw;
    logic [PLAYERS*BUTTONS-1:0] btn_raw;
    logic [PLAYERS-1:0]         start_raw;
    logic [PLAYERS-1:0]         coin_joy;
    logic [PLAYERS-1:0]         pause_joy;
    logic [PLAYERS-1:0]         coin_raw;
    logic [PLAYERS-1:0]         b0_next;

    always_comb begin
        coin_raw = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            coin_raw[p] = key_q[4+p] | ((COIN_SHARED != 0) ? 1'b0 : coin_joy[p]);
        end
        if (COIN_SHARED != 0) begin
            coin_raw[0] = coin_raw[0] | (|coin_joy);
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [15:0] j;
        logic [3:0]  kdir;
        logic [3:0]  kbtn;
        logic        unused_j;

        assign j = joy_i[16*p +: 16];

        // Only players 1 and 2 have directional and button keys.
        if (p < 2) begin : g_keys
            assign kdir = key_q[10+4*p +: 4];
            assign kbtn = key_q[18+4*p +: 4];
        end else begin : g_nokeys
            assign kdir = 4'b0000;
            assign kbtn = 4'b0000;
        end

        // kdir is {down, up, right, left}; joystick is R, L, D, U in bits 0..3.
        assign dir_raw[4*p+0] = kdir[0] | j[1];
        assign dir_raw[4*p+1] = kdir[1] | j[0];
        assign dir_raw[4*p+2] = kdir[2] | j[3];
        assign dir_raw[4*p+3] = kdir[3] | j[2];

        for (genvar k = 0; k < BUTTONS; k++) begin : g_btn
            assign btn_raw[p*BUTTONS+k] = kbtn[k] | j[4+k];
        end

        assign start_raw[p] = key_q[p] | j[4+BUTTONS];
        assign coin_joy[p]  = j[5+BUTTONS];
        assign pause_joy[p] = j[6+BUTTONS];
        assign unused_j     = ^{j, kbtn};

        // Coin stretcher
        coin_state_e    coin_state_q, coin_state_d;
        logic [CW-1:0]  coin_cnt_q, coin_cnt_d;
        logic           coin_prev_q;

        always_comb begin
            coin_state_d = coin_state_q;
            coin_cnt_d   = coin_cnt_q;
            case (coin_state_q)
                COIN_IDLE: begin
                    if (coin_raw[p] && !coin_prev_q) begin
                        coin_state_d = COIN_ACTIVE;
                        coin_cnt_d   = COIN_LAST;
                    end
                end
                COIN_ACTIVE: begin
                    if (coin_cnt_q == '0) begin
                        coin_state_d = COIN_IDLE;
                    end else begin
                        coin_cnt_d = coin_cnt_q - 1'b1;
                    end
                end
                default: coin_state_d = COIN_IDLE;
            endcase
        end

        always_ff @(posedge clk_49m_i) begin
            if (!reset_i) begin
                coin_state_q <= COIN_IDLE;
                coin_cnt_q   <= '0;
                coin_prev_q  <= 1'b0;
            end else begin
                coin_state_q <= coin_state_d;
                coin_cnt_q   <= coin_cnt_d;
                coin_prev_q  <= coin_raw[p];
            end
        end

        // The state register is the output register for the coin line.
        assign coin_o[p] = (coin_state_q != COIN_ACTIVE);

        // Autofire on button 0
        logic       af_prev_q;
        logic       af_phase_q, af_phase_d;
        logic [3:0] af_cnt_q, af_cnt_d;
        logic       b0;

        assign b0 = btn_raw[p*BUTTONS];

        always_comb begin
            af_phase_d = af_phase_q;
            af_cnt_d   = af_cnt_q;
            if (b0 && !af_prev_q) begin
                af_phase_d = 1'b1;
                af_cnt_d   = 4'd0;
            end else if (b0 && af_tick) begin
                // >= so a rate change that leaves cnt past the new limit
                // still toggles on the next tick.
                if (af_cnt_q >= af_half_m1) begin
                    af_cnt_d   = 4'd0;
                    af_phase_d = ~af_phase_q;
                end else begin
                    af_cnt_d = af_cnt_q + 4'd1;
                end
            end
        end

        always_ff @(posedge clk_49m_i) begin
            if (!reset_i) begin
                af_prev_q  <= 1'b0;
                af_phase_q <= 1'b1;
                af_cnt_q   <= 4'd0;
            end else begin
                af_prev_q  <= b0;
                af_phase_q <= af_phase_d;
                af_cnt_q   <= af_cnt_d;
            end
        end

        // Using the next phase lets the first shot land with the press.
        assign b0_next[p] = af_en_i[p] ? (b0 & af_phase_d) : b0;
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [PLAYERS*4-1:0]       p_dir_d, p_dir_q;
    logic [PLAYERS*BUTTONS-1:0] p_btn_d, p_btn_q;
    logic [PLAYERS-1:0]         start_d, start_q;
    logic                       service_d, service_q;
    logic                       pause_d, pause_q;

    always_comb begin
        p_dir_d = ~dir_raw;
        p_btn_d = ~btn_raw;
        for (int p = 0; p < PLAYERS; p++) begin
            p_btn_d[p*BUTTONS] = ~b0_next[p];
        end
        start_d   = ~start_raw;
        service_d = ~key_q[8];
        pause_d   = key_q[9] | (|pause_joy);
    end

    always_ff @(posedge clk_49m_i) begin
        if (!reset_i) begin
            p_dir_q   <= '1;
            p_btn_q   <= '1;
            start_q   <= '1;
            service_q <= 1'b1;
            pause_q   <= 1'b0;
        end else begin
            p_dir_q   <= p_dir_d;
            p_btn_q   <= p_btn_d;
            start_q   <= start_d;
            service_q <= service_d;
            pause_q   <= pause_d;
        end
    end

    assign p_dir_o     = p_dir_q;
    assign p_btn_o     = p_btn_q;
    assign start_o     = start_q;
    assign service_o   = service_q;
    assign pause_req_o = pause_q;

    logic unused_sink;
    assign unused_sink = ^{ps2_key_i[8], key_q};

endmodule
